sys_reset_seq: RTL and testbench

SYS_RESET_SEQ -- requirements
Module: sys_reset_seq

---
 rtl/sys_reset_seq.sv | 183 ++++++++++++++++++
 tb/tb_sys_reset_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sys_reset_seq.sv
// sys_reset_seq: collects the board, auxiliary, debugger and clock-lock reset
// sources, debounces the combined reset condition and then releases a chain
// of per-stage resets one after another, stage 0 first.
module sys_reset_seq #(
    parameter int NUM_STAGES      = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGE_GAP       = 8,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_reset_n_in,
    input  logic                  aux_reset_in,
    input  logic                  dbg_sys_rst,
    input  logic                  dcm_locked,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  seq_done,
    output logic [3:0]            rst_cause
);

    // Index must be able to count one past the last stage (up to 8).
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    // Synchronizer flops: *_meta_r is the first (possibly metastable) stage.
    logic ext_meta_r, aux_meta_r, dbg_meta_r, lock_meta_r;
    logic ext_s, aux_s, dbg_s, lock_s;

    logic       assert_s;
    logic [3:0] cause_now_s;

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]        idx_r, idx_nxt_s;
    logic [NUM_STAGES-1:0]   stage_reset_r, stage_nxt_s;
    logic                    done_r, done_nxt_s;
    logic [3:0]              cause_r, cause_nxt_s;

    // Two-flop synchronizers; reset loads values that keep the reset condition active.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta_r  <= 1'b0;
            aux_meta_r  <= 1'b0;
            dbg_meta_r  <= 1'b0;
            lock_meta_r <= 1'b0;
            ext_s       <= 1'b0;
            aux_s       <= 1'b0;
            dbg_s       <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            ext_meta_r  <= ext_reset_n_in;
            aux_meta_r  <= aux_reset_in;
            dbg_meta_r  <= dbg_sys_rst;
            lock_meta_r <= dcm_locked;
            ext_s       <= ext_meta_r;
            aux_s       <= aux_meta_r;
            dbg_s       <= dbg_meta_r;
            lock_s      <= lock_meta_r;
        end
    end

    assign assert_s    = ~ext_s | aux_s | dbg_s | ~lock_s;
    assign cause_now_s = {~lock_s, dbg_s, aux_s, ~ext_s};

    // Sequencer next-state logic; any active reset source wins over terminal counts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        stage_nxt_s = stage_reset_r;
        done_nxt_s  = done_r;
        cause_nxt_s = cause_r;
        case (state_r)
            ST_HOLD: begin
                stage_nxt_s = {NUM_STAGES{1'b1}};
                done_nxt_s  = 1'b0;
                cnt_nxt_s   = {CNT_W{1'b0}};
                idx_nxt_s   = {IDX_W{1'b0}};
                if (!assert_s) begin
                    state_nxt_s = ST_DEBOUNCE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DEBOUNCE: begin
                if (assert_s) begin
                    state_nxt_s = ST_HOLD;
                    stage_nxt_s = {NUM_STAGES{1'b1}};
                    done_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cause_nxt_s = cause_now_s;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s = ST_RELEASE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (assert_s) begin
                    state_nxt_s = ST_HOLD;
                    stage_nxt_s = {NUM_STAGES{1'b1}};
                    done_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cause_nxt_s = cause_now_s;
                end else if (cnt_r == GAP_LAST) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stage_nxt_s[i] = (IDX_W'(i) == idx_r) ? 1'b0 : stage_reset_r[i];
                    end
                    cnt_nxt_s = {CNT_W{1'b0}};
                    idx_nxt_s = idx_r + IDX_W'(1);
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_RUN;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RELEASE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (assert_s) begin
                    state_nxt_s = ST_HOLD;
                    stage_nxt_s = {NUM_STAGES{1'b1}};
                    done_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cause_nxt_s = cause_now_s;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                // Unreachable encoding: fall back to the safe all-in-reset state.
                state_nxt_s = ST_HOLD;
                stage_nxt_s = {NUM_STAGES{1'b1}};
                done_nxt_s  = 1'b0;
                cnt_nxt_s   = {CNT_W{1'b0}};
                idx_nxt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_HOLD;
            cnt_r         <= {CNT_W{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            stage_reset_r <= {NUM_STAGES{1'b1}};
            done_r        <= 1'b0;
            cause_r       <= 4'b0000;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            idx_r         <= idx_nxt_s;
            stage_reset_r <= stage_nxt_s;
            done_r        <= done_nxt_s;
            cause_r       <= cause_nxt_s;
        end
    end

    assign stage_reset  = stage_reset_r;
    assign stage_resetn = ~stage_reset_r;
    assign seq_done     = done_r;
    assign rst_cause    = cause_r;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Testbench for sys_reset_seq: directed scenarios plus random reset-source
// pulses, checked every cycle against a run-length model of the sequencer.
module tb_sys_reset_seq;

    localparam int N = 3;
    localparam int D = 16;
    localparam int G = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ext_n, aux, dbg, lock;
    logic [N-1:0] sr, srn;
    logic         done;
    logic [3:0]   cause;
    logic [0:0]   sr2, srn2;
    logic         done2;
    logic [3:0]   cause2;

    int n_checks = 0;
    int n_errors = 0;

    // Model: number of consecutive edges the sequencer has seen a clear reset condition.
    int         run_n   = 0;
    logic [3:0] m_cause = 4'b0000;
    logic       rst_d1  = 1'b1;
    logic       rst_d2  = 1'b1;
    logic [3:0] pins_d1 = 4'b1001;   // {lock, dbg, aux, ext_n}
    logic [3:0] pins_d2 = 4'b1001;
    logic [N-1:0] exp_sr;
    logic         exp_done;

    sys_reset_seq #(.NUM_STAGES(N), .DEBOUNCE_CYCLES(D), .STAGE_GAP(G), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ext_reset_n_in(ext_n), .aux_reset_in(aux),
        .dbg_sys_rst(dbg), .dcm_locked(lock), .stage_reset(sr),
        .stage_resetn(srn), .seq_done(done), .rst_cause(cause)
    );

    sys_reset_seq #(.NUM_STAGES(1), .DEBOUNCE_CYCLES(1), .STAGE_GAP(1), .CNT_W(4)) dut_min (
        .clk(clk), .rst(rst), .ext_reset_n_in(ext_n), .aux_reset_in(aux),
        .dbg_sys_rst(dbg), .dcm_locked(lock), .stage_reset(sr2),
        .stage_resetn(srn2), .seq_done(done2), .rst_cause(cause2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0] syn;
        logic       a_seen;
        syn    = (rst_d1 || rst_d2) ? 4'b0000 : pins_d2;
        a_seen = ~syn[0] | syn[1] | syn[2] | ~syn[3];
        if (rst) begin
            run_n   = 0;
            m_cause = 4'b0000;
        end else if (a_seen) begin
            if (run_n >= 1) m_cause = {~syn[3], syn[2], syn[1], ~syn[0]};
            run_n = 0;
        end else if (run_n < 100000) begin
            run_n++;
        end
        rst_d2  = rst_d1;
        rst_d1  = rst;
        pins_d2 = pins_d1;
        pins_d1 = {lock, dbg, aux, ext_n};
        for (int i = 0; i < N; i++) exp_sr[i] = (run_n < 1 + D + (i + 1) * G);
        exp_done = (run_n >= 1 + D + N * G);
    endtask

    task automatic tick();
        logic [N-1:0] exp_n;
        @(posedge clk);
        model_edge();
        #1;
        exp_n = ~exp_sr;
        check_val("stage_reset", sr, exp_sr);
        check_val("stage_resetn", srn, exp_n);
        check_val("seq_done", done, exp_done);
        check_val("rst_cause", cause, m_cause);
    endtask

    int pl[4];

    initial begin
        rst = 1'b1; ext_n = 1'b1; aux = 1'b0; dbg = 1'b0; lock = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("reset_stage_reset", sr, 3'b111);
        check_val("reset_seq_done", done, 1'b0);
        check_val("reset_rst_cause", cause, 4'b0000);
        check_val("reset_min_stage", sr2, 1'b1);

        // Release from reset with all pins inactive.
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 4)  check_val("min_before_release", sr2, 1'b1);
            if (k == 5)  check_val("min_released", sr2, 1'b0);
            if (k == 5)  check_val("min_done", done2, 1'b1);
            if (k == 5)  check_val("min_resetn", srn2, 1'b1);
            if (k == 26) check_val("stage0_not_early", sr, 3'b111);
            if (k == 27) check_val("stage0_release", sr, 3'b110);
            if (k == 35) check_val("stage1_release", sr, 3'b100);
            if (k == 42) check_val("done_not_early", done, 1'b0);
            if (k == 43) check_val("stage2_release", sr, 3'b000);
            if (k == 43) check_val("seq_done_rise", done, 1'b1);
        end

        // Clock lock lost while running.
        lock = 1'b0;
        tick();
        lock = 1'b1;
        tick();
        check_val("unlock_latency_k1", sr, 3'b000);
        tick();
        check_val("unlock_stage_reset", sr, 3'b111);
        check_val("unlock_seq_done", done, 1'b0);
        check_val("unlock_cause", cause, 4'b1000);
        for (int k = 0; k < 50; k++) tick();

        // Board reset glitch during debounce restarts the full debounce.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        ext_n = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        ext_n = 1'b1;
        check_val("ext_cause", cause, 4'b0001);
        check_val("ext_hold", sr, 3'b111);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 26) check_val("ext_stage0_not_early", sr, 3'b111);
            if (k == 27) check_val("ext_stage0_release", sr, 3'b110);
        end

        // Debugger reset after stage 0 release.
        dbg = 1'b1;
        tick();
        dbg = 1'b0;
        tick();
        tick();
        check_val("dbg_stage_reset", sr, 3'b111);
        check_val("dbg_cause", cause, 4'b0100);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 24) check_val("dbg_rerun_hold", sr, 3'b111);
            if (k == 25) check_val("dbg_rerun_stage0", sr, 3'b110);
        end

        // Synchronous reset in the middle of the release sequence.
        rst = 1'b1;
        tick();
        check_val("midrst_stage_reset", sr, 3'b111);
        check_val("midrst_cause", cause, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) tick();

        // Random short pulses on every reset source.
        for (int p = 0; p < 4; p++) pl[p] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (pl[p] > 0) pl[p]--;
                else if ($urandom_range(0, 599) == 0) pl[p] = int'($urandom_range(1, 8));
            end
            ext_n = !(pl[0] > 0);
            aux   = (pl[1] > 0);
            dbg   = (pl[2] > 0);
            lock  = !(pl[3] > 0);
            rst   = ($urandom_range(0, 799) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
